// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets and default window base shared by the MMIO controller files.
package mmio_pkg;
    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;
    localparam logic [7:0] IN_BASE = 8'h00;
    localparam logic [7:0] OUT_BASE = 8'h10;
    localparam logic [7:0] EVENT = 8'h20;
    localparam logic [7:0] MASK = 8'h21;
    localparam logic [7:0] CYCLE = 8'h22;
endpackage

// File: rtl/mmio_input_conditioner.sv
// mmio_input_conditioner: one input channel, 2-flop synchronizer plus debounce when MMIO_DEBOUNCE_EN is defined.
module mmio_input_conditioner #(
    parameter int DATA_WIDTH = 16,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] async_i,
    output logic [DATA_WIDTH-1:0] cond_o,
    output logic                  change_o
);
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("mmio_input_conditioner: DEBOUNCE_CYCLES must be at least 1");
    end
    logic [DATA_WIDTH-1:0] s1_q, s2_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
        end
    end
`ifdef MMIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DATA_WIDTH-1:0] acc_q, cand_q;
    logic [CW-1:0] cnt_q, run;
    // run length of identical synchronized samples, including the current one
    assign run = (s2_q == cand_q) ? cnt_q + 1'b1 : CW'(1);
    assign change_o = (s2_q != acc_q) && (run == CW'(DEBOUNCE_CYCLES));
    assign cond_o = acc_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cand_q <= '0;
            cnt_q <= '0;
        end else begin
            cand_q <= s2_q;
            cnt_q <= (s2_q == acc_q || change_o) ? '0 : run;
            if (change_o) acc_q <= s2_q;
        end
    end
`else
    assign cond_o = s2_q;
    assign change_o = s1_q != s2_q;
`endif
endmodule

// File: rtl/mmio_controller.sv
// mmio_controller: 256-word I/O window beside data memory with ports, events, mask/irq and a cycle counter.
// Define MMIO_DEBOUNCE_EN to debounce the input channels.
module mmio_controller import mmio_pkg::*; #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_IN = 2,
    parameter int NUM_OUT = 2,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE = ADDR_WIDTH'(IO_BASE_DEFAULT),
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ADDR_WIDTH-1:0]         cpu_address,
    input  logic [DATA_WIDTH-1:0]         cpu_write_data,
    input  logic                          cpu_write_enable,
    output logic [DATA_WIDTH-1:0]         cpu_read_data,
    input  logic [DATA_WIDTH-1:0]         mem_read_data,
    output logic                          mem_write_enable,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  in_ports,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_ports,
    output logic                          irq
);
    if (NUM_IN < 1 || NUM_IN > 16 || NUM_OUT < 1 || NUM_OUT > 16 || IO_BASE[7:0] != 8'h00) begin : g_bad_cfg
        $error("mmio_controller: illegal parameterization");
    end
    logic io_hit, io_wr, io_hit_q, irq_q;
    logic [7:0] offset;
    logic [DATA_WIDTH-1:0] rd_d, rd_q, cycle_d, cycle_q;
    logic [NUM_IN-1:0] event_d, event_q, mask_d, mask_q, change;
    logic [NUM_IN*DATA_WIDTH-1:0] cond;
    logic [NUM_OUT*DATA_WIDTH-1:0] out_d, out_q;
    assign io_hit = cpu_address[ADDR_WIDTH-1:8] == IO_BASE[ADDR_WIDTH-1:8];
    assign offset = cpu_address[7:0];
    assign io_wr = cpu_write_enable && io_hit;
    assign mem_write_enable = cpu_write_enable && !io_hit;
    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        mmio_input_conditioner #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clock(clock),
            .reset(reset),
            .async_i(in_ports[i*DATA_WIDTH +: DATA_WIDTH]),
            .cond_o(cond[i*DATA_WIDTH +: DATA_WIDTH]),
            .change_o(change[i])
        );
    end
    always_comb begin
        rd_d = offset == EVENT ? DATA_WIDTH'(event_q) :
               offset == MASK  ? DATA_WIDTH'(mask_q) :
               offset == CYCLE ? cycle_q : '0;
        for (int k = 0; k < NUM_IN; k++)
            if (offset == 8'(IN_BASE + k)) rd_d = cond[k*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 0; k < NUM_OUT; k++)
            if (offset == 8'(OUT_BASE + k)) rd_d = out_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
    always_comb begin
        out_d = out_q;
        for (int k = 0; k < NUM_OUT; k++)
            if (io_wr && offset == 8'(OUT_BASE + k)) out_d[k*DATA_WIDTH +: DATA_WIDTH] = cpu_write_data;
    end
    // a new input change outranks a same-edge write-one-to-clear
    assign event_d = (event_q & ~((io_wr && offset == EVENT) ? cpu_write_data[NUM_IN-1:0] : '0)) | change;
    assign mask_d = (io_wr && offset == MASK) ? cpu_write_data[NUM_IN-1:0] : mask_q;
    assign cycle_d = (io_wr && offset == CYCLE) ? cpu_write_data : cycle_q + 1'b1;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_hit_q <= 1'b0;
            rd_q <= '0;
            out_q <= '0;
            event_q <= '0;
            mask_q <= '0;
            cycle_q <= '0;
            irq_q <= 1'b0;
        end else begin
            io_hit_q <= io_hit;
            rd_q <= rd_d;
            out_q <= out_d;
            event_q <= event_d;
            mask_q <= mask_d;
            cycle_q <= cycle_d;
            irq_q <= |(event_q & mask_q);
        end
    end
    assign cpu_read_data = io_hit_q ? rd_q : mem_read_data;
    assign out_ports = out_q;
    assign irq = irq_q;
endmodule

// File: tb/tb_mmio_controller.sv
// tb_mmio_controller: directed and randomized checks of mmio_controller against a cycle-level reference model.
module tb_mmio_controller;
    localparam int DW = 16;
    localparam int NI = 2;
    localparam int NO = 2;
    localparam int DC = 16;
    localparam logic [15:0] IDLE = 16'h0100;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [15:0] cpu_address = '0, cpu_write_data = '0, mem_read_data = '0, cpu_read_data;
    logic cpu_write_enable = 1'b0, mem_write_enable, irq;
    logic [NI*DW-1:0] in_ports = '0;
    logic [NO*DW-1:0] out_ports;
    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] out_m [NO];
    logic [DW-1:0] cond_m [NI];
    logic [DW-1:0] cyc_m, rd_m;
    logic [NI-1:0] ev_m, mk_m;
    logic hit_m, irq_m;
    logic [NI*DW-1:0] inh [$];
    logic [7:0] offs [10] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h37};

    mmio_controller #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(16), .NUM_IN(NI), .NUM_OUT(NO),
        .IO_BASE(16'hFF00), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
        .cpu_write_enable(cpu_write_enable), .cpu_read_data(cpu_read_data),
        .mem_read_data(mem_read_data), .mem_write_enable(mem_write_enable),
        .in_ports(in_ports), .out_ports(out_ports), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] reg_val(input logic [7:0] off);
        for (int k = 0; k < NI; k++) if (off == 8'(k)) return cond_m[k];
        for (int k = 0; k < NO; k++) if (off == 8'(16 + k)) return out_m[k];
        if (off == 8'h20) return DW'(ev_m);
        if (off == 8'h21) return DW'(mk_m);
        if (off == 8'h22) return cyc_m;
        return '0;
    endfunction

    task automatic model_reset();
        foreach (out_m[k]) out_m[k] = '0;
        foreach (cond_m[k]) cond_m[k] = '0;
        cyc_m = '0;
        rd_m = '0;
        ev_m = '0;
        mk_m = '0;
        hit_m = 1'b0;
        irq_m = 1'b0;
        inh.delete();
        repeat (DC + 2) inh.push_front('0);
    endtask

    // advance the reference by one rising edge using the inputs currently applied
    task automatic model_step();
        logic hit, wr;
        logic [7:0] off;
        logic [NI-1:0] chg;
        logic [DW-1:0] nxt;
        hit = cpu_address[15:8] == 8'hFF;
        off = cpu_address[7:0];
        wr = cpu_write_enable && hit;
        chg = '0;
        rd_m = reg_val(off);
        irq_m = |(ev_m & mk_m);
        inh.push_front(in_ports);
        void'(inh.pop_back());
        for (int k = 0; k < NI; k++) begin
`ifdef MMIO_DEBOUNCE_EN
            nxt = inh[2][k*DW +: DW];
            for (int j = 3; j < DC + 2; j++) if (inh[j][k*DW +: DW] != nxt) nxt = cond_m[k];
`else
            nxt = inh[1][k*DW +: DW];
`endif
            chg[k] = nxt != cond_m[k];
            cond_m[k] = nxt;
        end
        if (wr && off == 8'h20) ev_m = ev_m & ~cpu_write_data[NI-1:0];
        ev_m = ev_m | chg;
        if (wr && off == 8'h21) mk_m = cpu_write_data[NI-1:0];
        for (int k = 0; k < NO; k++) if (wr && off == 8'(16 + k)) out_m[k] = cpu_write_data;
        cyc_m = (wr && off == 8'h22) ? cpu_write_data : cyc_m + 16'd1;
        hit_m = hit;
    endtask

    task automatic cyc(input logic [15:0] a, input logic we, input logic [15:0] wd, input logic [15:0] md);
        cpu_address = a;
        cpu_write_enable = we;
        cpu_write_data = wd;
        mem_read_data = md;
        @(negedge clock);
        check("rdata", cpu_read_data, hit_m ? rd_m : md);
        check("mwe", mem_write_enable, we && a[15:8] != 8'hFF);
        check("out", out_ports, {out_m[1], out_m[0]});
        check("irq", irq, irq_m);
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        mem_read_data = '0;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_out", out_ports, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", cpu_read_data, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        model_step();
        #1;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();
`ifndef MMIO_DEBOUNCE_EN
        in_ports = 32'h0003_0000;
        cyc(IDLE, 0, 0, 0);
        cyc(IDLE, 0, 0, 0);
        cyc(16'hFF01, 0, 0, 16'hBEEF);
        check("in1", cpu_read_data, 16'h0003);
        cyc(16'hFF20, 0, 0, 0);
        check("event_set", cpu_read_data, 16'h0002);
        cyc(16'hFF21, 1, 16'h0002, 0);
        cyc(IDLE, 0, 0, 0);
        check("irq_set", irq, 1);
        cyc(16'hFF20, 1, 16'h0002, 0);
        cyc(IDLE, 0, 0, 0);
        check("irq_clr", irq, 0);
        cyc(16'hFF20, 0, 0, 0);
        check("event_clr", cpu_read_data, 16'h0000);
`else
        in_ports[15:0] = 16'h00F0;
        repeat (DC + 4) cyc(IDLE, 0, 0, 0);
        cyc(16'hFF20, 1, 16'hFFFF, 0);
        for (int t = 0; t <= 40; t++) begin
            if (t % 5 == 0) in_ports[15:0] = in_ports[15:0] ^ 16'h000F;
            cyc(IDLE, 0, 0, 0);
        end
        cyc(16'hFF00, 0, 0, 0);
        check("db_hold", cpu_read_data, 16'h00F0);
        cyc(16'hFF20, 0, 0, 0);
        check("db_noev", cpu_read_data[0], 0);
        repeat (DC + 2) cyc(IDLE, 0, 0, 0);
        cyc(16'hFF00, 0, 0, 0);
        check("db_take", cpu_read_data, 16'h00FF);
        cyc(16'hFF20, 0, 0, 0);
        check("db_event", cpu_read_data[0], 1);
`endif
        cyc(16'hFF10, 1, 16'h00A5, 16'h1111);
        check("out0_store", out_ports[15:0], 16'h00A5);
        check("mwe_io", mem_write_enable, 0);
        cyc(16'hFF10, 0, 0, 16'h5555);
        check("out0_load", cpu_read_data, 16'h00A5);
        cyc(16'h0040, 0, 0, 16'h1234);
        check("mem_load", cpu_read_data, 16'h1234);
        cyc(16'h0040, 1, 16'h7777, 16'h1234);
        check("mwe_mem", mem_write_enable, 1);
        cyc(16'hFF22, 1, 16'hFFFE, 0);
        cyc(IDLE, 0, 0, 0);
        cyc(16'hFF22, 0, 0, 0);
        check("cycle_ffff", cpu_read_data, 16'hFFFF);
        cyc(16'hFF22, 0, 0, 0);
        check("cycle_wrap", cpu_read_data, 16'h0000);
`ifndef MMIO_DEBOUNCE_EN
        in_ports[15:0] = in_ports[15:0] ^ 16'h0001;
        cyc(IDLE, 0, 0, 0);
        cyc(16'hFF20, 1, 16'h0001, 0);
        cyc(16'hFF20, 0, 0, 0);
        check("w1c_race", cpu_read_data[0], 1);
`endif
        cpu_address = 16'hFF22;
        cpu_write_enable = 1'b0;
        #2;
        do_reset();
        cyc(16'hFF10, 0, 0, 16'h9999);
        check("load_after_rst", cpu_read_data, 16'h0000);
        for (int n = 0; n < 600; n++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 9) < 7) ? {8'hFF, offs[$urandom_range(0, 9)]} : 16'($urandom);
            if ($urandom_range(0, 9) == 0) in_ports[$urandom_range(0, NI*DW-1)] ^= 1'b1;
            if (n == 300) begin
                cpu_address = a;
                #2;
                do_reset();
            end
            cyc(a, $urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
